// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load-data formatting and writeback source select.
// The register feeds the regfile write port and the EX forwarding unit.
// The regfile writes on negedge, so rd_* settle half a cycle before each write.
// Optional retire counter: define WB_RETIRE_CNT_EN to add the counter and the retire_cnt_o port.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            mem_valid_i,
    input  logic            mem_rd_wren_i,
    input  logic [4:0]      mem_rd_addr_i,
    input  logic [1:0]      mem_wb_sel_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [XLEN-1:0] mem_alu_i,
    input  logic [XLEN-1:0] mem_ld_data_i,
    input  logic [XLEN-1:0] mem_pc4_i,
    input  logic [XLEN-1:0] mem_imm_i,
    output logic            rd_wren,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rd_data,
    output logic            wb_valid_o,
    output logic            fwd_wren_o,
    output logic [4:0]      fwd_addr_o,
    output logic [XLEN-1:0] fwd_data_o
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt_o
`endif
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic [1:0]      ld_off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;
    logic [XLEN-1:0] wb_data_next;
    logic            wb_wren_next;
    logic            capture;

    assign capture = !flush_i && !stall_i;

    // Extract and extend load data, then pick the writeback source.
    always_comb begin
        ld_off  = mem_alu_i[1:0];
        ld_byte = mem_ld_data_i[{ld_off, 3'b000} +: 8];
        // Halfword select ignores off[0]; misalignment traps upstream.
        ld_half = ld_off[1] ? mem_ld_data_i[31:16] : mem_ld_data_i[15:0];
        ld_fmt  = mem_ld_data_i;
        case (mem_funct3_i)
            F3_LB:   ld_fmt = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            F3_LBU:  ld_fmt = {{(XLEN-8){1'b0}}, ld_byte};
            F3_LH:   ld_fmt = {{(XLEN-16){ld_half[15]}}, ld_half};
            F3_LHU:  ld_fmt = {{(XLEN-16){1'b0}}, ld_half};
            default: ld_fmt = mem_ld_data_i;
        endcase

        wb_data_next = mem_imm_i;
        case (mem_wb_sel_i)
            SEL_ALU:  wb_data_next = mem_alu_i;
            SEL_LOAD: wb_data_next = ld_fmt;
            SEL_PC4:  wb_data_next = mem_pc4_i;
            default:  wb_data_next = mem_imm_i;
        endcase

        wb_wren_next = mem_valid_i && mem_rd_wren_i && (mem_rd_addr_i != 5'd0);
    end

    // WB pipeline register: reset > flush > stall > capture.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wb_valid_o <= 1'b0;
            rd_wren    <= 1'b0;
            rd_addr    <= 5'd0;
            rd_data    <= '0;
        end else if (flush_i) begin
            wb_valid_o <= 1'b0;
            rd_wren    <= 1'b0;
        end else if (!stall_i) begin
            wb_valid_o <= mem_valid_i;
            rd_wren    <= wb_wren_next;
            rd_addr    <= mem_rd_addr_i;
            rd_data    <= wb_data_next;
        end
    end

    assign fwd_wren_o = rd_wren;
    assign fwd_addr_o = rd_addr;
    assign fwd_data_o = rd_data;

`ifdef WB_RETIRE_CNT_EN
    // Count instructions that actually enter WB; wraps naturally at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            retire_cnt_o <= '0;
        end else if (capture && mem_valid_i) begin
            retire_cnt_o <= retire_cnt_o + 1'b1;
        end
    end
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load formatting, source select, x0 suppression,
// stall/flush priority, mid-stream reset, and the optional retire counter.
module tb_wb_stage;

    localparam int CNT_W = 4;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        flush_i;
    logic        mem_valid_i;
    logic        mem_rd_wren_i;
    logic [4:0]  mem_rd_addr_i;
    logic [1:0]  mem_wb_sel_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_alu_i;
    logic [31:0] mem_ld_data_i;
    logic [31:0] mem_pc4_i;
    logic [31:0] mem_imm_i;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wb_valid_o;
    logic        fwd_wren_o;
    logic [4:0]  fwd_addr_o;
    logic [31:0] fwd_data_o;
`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    wb_stage #(.XLEN(32), .CNT_W(CNT_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .mem_valid_i   (mem_valid_i),
        .mem_rd_wren_i (mem_rd_wren_i),
        .mem_rd_addr_i (mem_rd_addr_i),
        .mem_wb_sel_i  (mem_wb_sel_i),
        .mem_funct3_i  (mem_funct3_i),
        .mem_alu_i     (mem_alu_i),
        .mem_ld_data_i (mem_ld_data_i),
        .mem_pc4_i     (mem_pc4_i),
        .mem_imm_i     (mem_imm_i),
        .rd_wren       (rd_wren),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .wb_valid_o    (wb_valid_o),
        .fwd_wren_o    (fwd_wren_o),
        .fwd_addr_o    (fwd_addr_o),
        .fwd_data_o    (fwd_data_o)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt_o  (retire_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Checks the full architectural output set, including the forwarding copies.
    task automatic chk_out(input string tag, input logic valid, input logic wren,
                           input logic [4:0] addr, input logic [31:0] data);
        chk({tag, ".valid"}, 64'(wb_valid_o), 64'(valid));
        chk({tag, ".wren"},  64'(rd_wren),    64'(wren));
        chk({tag, ".addr"},  64'(rd_addr),    64'(addr));
        chk({tag, ".data"},  64'(rd_data),    64'(data));
        chk({tag, ".fwren"}, 64'(fwd_wren_o), 64'(wren));
        chk({tag, ".faddr"}, 64'(fwd_addr_o), 64'(addr));
        chk({tag, ".fdata"}, 64'(fwd_data_o), 64'(data));
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] rd,
                         input logic [1:0] sel, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc4, input logic [31:0] imm);
        mem_valid_i   = v;
        mem_rd_wren_i = we;
        mem_rd_addr_i = rd;
        mem_wb_sel_i  = sel;
        mem_funct3_i  = f3;
        mem_alu_i     = alu;
        mem_ld_data_i = ld;
        mem_pc4_i     = pc4;
        mem_imm_i     = imm;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni  = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        drive(1'b1, 1'b1, 5'd9, 2'b00, 3'b010, 32'h5555_AAAA, 32'h0, 32'h0, 32'h0);
        tick();
        chk_out("reset", 1'b0, 1'b0, 5'd0, 32'h0);

        rst_ni = 1'b1;
        // LB off=1
        drive(1'b1, 1'b1, 5'd5, 2'b01, 3'b000, 32'h0000_1001, 32'h1234_80FF, 32'h0, 32'h0);
        tick();
        chk_out("lb_off1", 1'b1, 1'b1, 5'd5, 32'hFFFF_FF80);

        drive(1'b1, 1'b1, 5'd6, 2'b01, 3'b101, 32'h0000_0002, 32'h1234_80FF, 32'h0, 32'h0);
        tick();
        chk_out("lhu_off2", 1'b1, 1'b1, 5'd6, 32'h0000_1234);

        drive(1'b1, 1'b1, 5'd7, 2'b01, 3'b001, 32'h0000_0000, 32'h1234_80FF, 32'h0, 32'h0);
        tick();
        chk("lh_off0", 64'(rd_data), 64'h0000_0000_FFFF_80FF);

        drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b100, 32'h0000_0003, 32'h1234_80FF, 32'h0, 32'h0);
        tick();
        chk("lbu_off3", 64'(rd_data), 64'h0000_0000_0000_0012);

        drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b000, 32'h0000_0000, 32'h1234_80FF, 32'h0, 32'h0);
        tick();
        chk("lb_off0", 64'(rd_data), 64'h0000_0000_FFFF_FFFF);

        drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b101, 32'h0000_0003, 32'h8765_4321, 32'h0, 32'h0);
        tick();
        chk("lhu_off3", 64'(rd_data), 64'h0000_0000_0000_8765);

        drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b001, 32'h0000_0002, 32'h8765_4321, 32'h0, 32'h0);
        tick();
        chk("lh_off2", 64'(rd_data), 64'h0000_0000_FFFF_8765);

        drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b010, 32'h0000_0003, 32'h8765_4321, 32'h0, 32'h0);
        tick();
        chk("lw_off3", 64'(rd_data), 64'h0000_0000_8765_4321);

        drive(1'b1, 1'b1, 5'd8, 2'b01, 3'b011, 32'h0000_0001, 32'h8765_4321, 32'h0, 32'h0);
        tick();
        chk("ld_undef", 64'(rd_data), 64'h0000_0000_8765_4321);

        // PC+4 to x0: write suppressed, still a valid instruction
        drive(1'b1, 1'b1, 5'd0, 2'b10, 3'b000, 32'h1111_1111, 32'h0, 32'h0000_0104, 32'h0);
        tick();
        chk_out("pc4_x0", 1'b1, 1'b0, 5'd0, 32'h0000_0104);

        drive(1'b1, 1'b1, 5'd31, 2'b11, 3'b000, 32'h1111_1111, 32'h0, 32'h0000_0104, 32'hABCD_E000);
        tick();
        chk_out("lui", 1'b1, 1'b1, 5'd31, 32'hABCD_E000);

        drive(1'b1, 1'b0, 5'd4, 2'b00, 3'b000, 32'h0000_00AA, 32'h0, 32'h0, 32'h0);
        tick();
        chk_out("no_wren", 1'b1, 1'b0, 5'd4, 32'h0000_00AA);

        drive(1'b0, 1'b1, 5'd4, 2'b00, 3'b000, 32'h0000_00BB, 32'h0, 32'h0, 32'h0);
        tick();
        chk_out("bubble", 1'b0, 1'b0, 5'd4, 32'h0000_00BB);

        // ALU result then 3 stall cycles with changing inputs
        drive(1'b1, 1'b1, 5'd3, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        tick();
        chk_out("alu", 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 5'(10 + i), 2'b00, 3'b000, 32'h0000_1000 + 32'(i), 32'h0, 32'h0, 32'h0);
            tick();
            chk_out($sformatf("stall%0d", i), 1'b1, 1'b1, 5'd3, 32'hDEAD_BEEF);
        end
        stall_i = 1'b0;
        tick();
        chk_out("unstall", 1'b1, 1'b1, 5'd12, 32'h0000_1002);

        // flush beats a simultaneous stall
        stall_i = 1'b1;
        flush_i = 1'b1;
        drive(1'b1, 1'b1, 5'd13, 2'b00, 3'b000, 32'h0000_2222, 32'h0, 32'h0, 32'h0);
        tick();
        chk("flush.valid", 64'(wb_valid_o), 64'd0);
        chk("flush.wren",  64'(rd_wren),    64'd0);
        chk("flush.fwren", 64'(fwd_wren_o), 64'd0);
        stall_i = 1'b0;
        flush_i = 1'b0;
        tick();
        chk_out("post_flush", 1'b1, 1'b1, 5'd13, 32'h0000_2222);

        rst_ni = 1'b0;
        tick();
        chk_out("mid_reset", 1'b0, 1'b0, 5'd0, 32'h0);
        rst_ni = 1'b1;

`ifdef WB_RETIRE_CNT_EN
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("cnt_reset", 64'(retire_cnt_o), 64'd0);
        drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 32'h0);
        // 10 captures, 2 flushes, 3 stalls, interleaved
        for (int i = 0; i < 15; i++) begin
            flush_i = (i == 2) || (i == 9);
            stall_i = (i == 4) || (i == 6) || (i == 12);
            tick();
        end
        flush_i = 1'b0;
        stall_i = 1'b0;
        chk("cnt_ten", 64'(retire_cnt_o), 64'd10);
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_ones", 64'(retire_cnt_o), 64'd15);
        tick();
        chk("cnt_wrap", 64'(retire_cnt_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
